tally_readout: RTL and testbench
================================

Name: tally_readout

Overview:
- Reader end of the vote-storage path: on request, takes a consistent snapshot of all candidate vote counts and voter statuses.
- Serialises the snapshot as a fixed-length byte frame over a valid/ready stream, computing the winner/tie byte and an XOR checksum on the fly.
- Sits beside the memory control unit at the top level and feeds a display/UART/host link.

Parameters:
- NUM_CAND, 3, number of candidates (1..15)
- NUM_VOTER, 4, number of voters (1..15)
- CW, 4, width of each vote count and voter status field (must be 4)
- HDR, 8'hA5, frame header byte

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- cand_counts  input  NUM_CAND*CW  packed counts; candidate i at bits [i*CW +: CW]
- voter_status  input  NUM_VOTER*CW  packed statuses; voter j at bits [j*CW +: CW]
- start  input  1  request a readout; sampled only in IDLE
- out_ready  input  1  sink can accept a byte
- out_valid  output  1  out_data holds a valid byte
- out_data  output  8  frame byte
- busy  output  1  high from the snapshot cycle through the last byte accepted
- done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, busy=0, done=0, FSM in IDLE, snapshot registers, index, running max, tie flag and checksum all 0.
- Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- FSM states: IDLE -> HEADER -> CAND -> VOTER -> WINNER -> CHECK -> IDLE.
- IDLE:
  - start=1 at edge N registers both input buses into the snapshot, clears the checksum, clears the running max to 0, sets the winner index to 4'hF, and moves to HEADER.
  - At N+1: busy=1, out_valid=1, out_data=HDR.
- Stream rule: a byte transfers on an edge where out_valid&&out_ready. out_data and out_valid stay stable until that transfer. out_valid drops only after CHECK transfers.
- Checksum: every transferred byte except the checksum itself is XORed into it.
- Next byte: presented on the cycle after a transfer. With out_ready tied high, one byte per cycle and no bubbles.
- CAND: bytes {i[3:0], count_i[3:0]} for i=0..NUM_CAND-1. On each transfer, update the running max:
  - count_i > max: max=count_i, winner=i, tie=0.
  - count_i == max and max != 0: tie=1.
- VOTER: bytes {j[3:0], status_j[3:0]} for j=0..NUM_VOTER-1.
- WINNER: byte {tie, 3'b000, winner[3:0]}.
  - Lowest index wins ties.
  - All counts zero gives 8'h0F.
- CHECK: byte = checksum of all preceding bytes. On its transfer: out_valid=0, busy=0, done=1 for one cycle, return to IDLE.
- Next start accepted on the cycle after done (a start asserted in the same cycle as done is accepted).
- Frame length is 3+NUM_CAND+NUM_VOTER bytes (10 by default).
- Snapshot isolation: changes on cand_counts/voter_status while busy do not affect the frame in flight.
- start while busy is ignored and not queued.
- Index counter is 4 bits and resets to 0 between phases. No wrap beyond NUM_CAND-1 or NUM_VOTER-1.

Decomposition:
- Shared package evm_pkg:
  - State enum for the readout FSM.
  - Default HDR constant.
  - Field widths CW and IDX_W=4.
  - Sentinel NO_WINNER=4'hF.
- One sub-module, tally_max_tracker: holds running max, winner index and tie flag; clear/update-enable interface; driven by the CAND transfers.

Test Plan:
- counts c0=2,c1=3,c2=1, statuses 1,0,1,1, out_ready=1, start pulse -> bytes A5,02,13,21,01,10,21,31,01,95 on 10 consecutive cycles; done pulses once; busy high for exactly those 10 cycles.
- Tie: counts 3,3,0 -> winner byte 8'h80. All counts 0 -> winner byte 8'h0F. Checksum matches the XOR of the preceding 9 bytes in both cases.
- Backpressure: random out_ready with 30% duty -> same byte sequence as case 1; out_data stable whenever out_valid&&!out_ready; no byte lost or duplicated.
- Snapshot isolation: change cand_counts to 4'hF each on the cycle after start -> frame still carries the values sampled at start. start pulses while busy -> ignored; exactly one frame.
- Reset mid-frame: assert rst during the VOTER phase -> out_valid, busy, done all 0 immediately. A following start yields a complete, correct frame beginning with A5.
- Back-to-back: start held high continuously -> consecutive frames separated by no more than 1 idle cycle, each frame identical and correct.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and constants for the vote-storage readout path.
package evm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CAND,
        S_VOTER,
        S_WINNER,
        S_CHECK
    } rd_state_t;

    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
    localparam int          CW          = 4;
    localparam int          IDX_W       = 4;
    localparam logic [3:0]  NO_WINNER   = 4'hF;

endpackage

// File: rtl/tally_max_tracker.sv
// Running maximum, winner index and tie flag over the candidate bytes of a frame.
// One update per enabled cycle; lowest index keeps the win on equal counts.
module tally_max_tracker
    import evm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd_en,
    input  logic [CW-1:0]    cnt,
    input  logic [IDX_W-1:0] cnt_idx,
    output logic [IDX_W-1:0] winner,
    output logic             tie
);

    logic [CW-1:0] max_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_cnt <= '0;
            winner  <= '0;
            tie     <= 1'b0;
        end else if (clr) begin
            max_cnt <= '0;
            winner  <= NO_WINNER;
            tie     <= 1'b0;
        end else if (upd_en) begin
            if (cnt > max_cnt) begin
                max_cnt <= cnt;
                winner  <= cnt_idx;
                tie     <= 1'b0;
            end else if (cnt == max_cnt && max_cnt != '0) begin
                tie     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tally_readout.sv
// Snapshots candidate counts and voter statuses on start and streams them as a
// fixed-length byte frame (header, counts, statuses, winner, XOR checksum).
module tally_readout #(
    parameter int         NUM_CAND  = 3,
    parameter int         NUM_VOTER = 4,
    parameter int         CW        = evm_pkg::CW,
    parameter logic [7:0] HDR       = evm_pkg::HDR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CAND*CW-1:0]    cand_counts,
    input  logic [NUM_VOTER*CW-1:0]   voter_status,
    input  logic                      start,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    output logic                      busy,
    output logic                      done
);
    import evm_pkg::*;

    localparam logic [IDX_W-1:0] LAST_CAND  = IDX_W'(NUM_CAND - 1);
    localparam logic [IDX_W-1:0] LAST_VOTER = IDX_W'(NUM_VOTER - 1);

    rd_state_t                 state;
    logic [NUM_CAND*CW-1:0]    snap_cand;
    logic [NUM_VOTER*CW-1:0]   snap_voter;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          nidx;
    logic [7:0]                chk;
    logic [IDX_W-1:0]          winner;
    logic                      tie;
    logic                      xfer;

    assign xfer = out_valid && out_ready;
    assign nidx = idx + IDX_W'(1);

    function automatic logic [CW-1:0] cand_at(input logic [IDX_W-1:0] i);
        return snap_cand[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] voter_at(input logic [IDX_W-1:0] i);
        return snap_voter[i*CW +: CW];
    endfunction

    // Tracker sees each count on the edge its byte is accepted, so it has
    // settled long before the winner byte is built at the end of VOTER.
    tally_max_tracker u_max (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_IDLE && start),
        .upd_en  (state == S_CAND && xfer),
        .cnt     (cand_at(idx)),
        .cnt_idx (idx),
        .winner  (winner),
        .tie     (tie)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            snap_cand  <= '0;
            snap_voter <= '0;
            idx        <= '0;
            chk        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    snap_cand  <= cand_counts;
                    snap_voter <= voter_status;
                    chk        <= '0;
                    idx        <= '0;
                    out_valid  <= 1'b1;
                    out_data   <= HDR;
                    busy       <= 1'b1;
                    state      <= S_HEADER;
                end
                S_HEADER: if (xfer) begin
                    chk      <= chk ^ out_data;
                    idx      <= '0;
                    out_data <= {IDX_W'(0), cand_at(IDX_W'(0))};
                    state    <= S_CAND;
                end
                S_CAND: if (xfer) begin
                    chk <= chk ^ out_data;
                    if (idx == LAST_CAND) begin
                        idx      <= '0;
                        out_data <= {IDX_W'(0), voter_at(IDX_W'(0))};
                        state    <= S_VOTER;
                    end else begin
                        idx      <= nidx;
                        out_data <= {nidx, cand_at(nidx)};
                    end
                end
                S_VOTER: if (xfer) begin
                    chk <= chk ^ out_data;
                    if (idx == LAST_VOTER) begin
                        idx      <= '0;
                        out_data <= {tie, 3'b000, winner};
                        state    <= S_WINNER;
                    end else begin
                        idx      <= nidx;
                        out_data <= {nidx, voter_at(nidx)};
                    end
                end
                S_WINNER: if (xfer) begin
                    chk      <= chk ^ out_data;
                    out_data <= chk ^ out_data;
                    state    <= S_CHECK;
                end
                S_CHECK: if (xfer) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tally_readout.sv
// Scoreboard bench for tally_readout: expected frame bytes are queued when a
// readout is requested and popped as the DUT hands bytes over.
module tb_tally_readout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cand_counts = '0;
    logic [15:0] voter_status = '0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    logic       held_vld = 1'b0;
    logic [7:0] held_dat = '0;

    tally_readout dut (
        .clk          (clk),
        .rst          (rst),
        .cand_counts  (cand_counts),
        .voter_status (voter_status),
        .start        (start),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Independent frame model: winner is the first index holding the overall
    // maximum; tie when more than one index holds a non-zero maximum.
    task automatic push_model(input logic [11:0] c, input logic [15:0] s);
        logic [7:0] x;
        logic [7:0] b;
        logic [3:0] mx;
        logic [3:0] w;
        logic [3:0] v;
        int         nmax;
        x = 8'hA5;
        exp_q.push_back(8'hA5);
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            v = c[i*4 +: 4];
            if (v > mx) mx = v;
            b = {i[3:0], v};
            exp_q.push_back(b);
            x ^= b;
        end
        for (int j = 0; j < 4; j++) begin
            b = {j[3:0], s[j*4 +: 4]};
            exp_q.push_back(b);
            x ^= b;
        end
        nmax = 0;
        w = 4'hF;
        for (int i = 2; i >= 0; i--) begin
            if (c[i*4 +: 4] == mx && mx != 0) begin
                nmax++;
                w = i[3:0];
            end
        end
        b = {(nmax > 1), 3'b000, w};
        exp_q.push_back(b);
        x ^= b;
        exp_q.push_back(x);
    endtask

    function automatic logic rnd_ready(input int pct);
        return (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
    endfunction

    task automatic run_frame(input int pct, input string tag);
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = rnd_ready(pct);
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = rnd_ready(pct);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            out_ready = rnd_ready(pct);
            n++;
        end
        chk({tag, "_done_seen"}, (n < 400), 1);
        out_ready = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each accepted byte and checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (held_vld && out_valid) chk("hold_stable", out_data, held_dat);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", 1, 0);
                else chk("frame_byte", out_data, exp_q.pop_front());
            end
            held_vld = out_valid && !out_ready;
            held_dat = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] case1 [10];
        int         n;
        int         frames;
        int         idle;
        logic       seen_busy;

        case1 = '{8'hA5, 8'h02, 8'h13, 8'h21, 8'h01, 8'h10, 8'h21, 8'h31, 8'h01, 8'h95};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame against the literal byte list
        cand_counts  = 12'h132;
        voter_status = 16'h1101;
        foreach (case1[i]) exp_q.push_back(case1[i]);
        busy_cnt = 0;
        done_cnt = 0;
        run_frame(100, "basic");
        repeat (3) @(posedge clk);
        #1;
        chk("basic_busy_cycles", busy_cnt, 10);
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_queue_empty", exp_q.size(), 0);

        // Tie and all-zero winner bytes
        cand_counts = 12'h033;
        push_model(12'h033, 16'h1101);
        run_frame(100, "tie");
        cand_counts = 12'h000;
        voter_status = 16'h2345;
        push_model(12'h000, 16'h2345);
        run_frame(100, "zero");
        repeat (2) @(posedge clk);
        chk("tie_zero_queue_empty", exp_q.size(), 0);

        // Backpressure with ~30% ready
        cand_counts  = 12'h132;
        voter_status = 16'h1101;
        foreach (case1[i]) exp_q.push_back(case1[i]);
        run_frame(30, "bp");
        repeat (2) @(posedge clk);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Snapshot isolation and ignored start while busy
        cand_counts  = 12'h7A5;
        voter_status = 16'h9C3E;
        push_model(12'h7A5, 16'h9C3E);
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cand_counts  = 12'hFFF;
        voter_status = 16'h0000;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            start = (n == 3 || n == 5);
            n++;
        end
        start = 1'b0;
        chk("snap_done_seen", (n < 400), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("snap_idle_busy", busy, 0);
        chk("snap_idle_valid", out_valid, 0);
        chk("snap_one_frame", done_cnt, 1);
        chk("snap_queue_empty", exp_q.size(), 0);

        // Reset during VOTER phase
        cand_counts  = 12'h132;
        voter_status = 16'h1101;
        push_model(12'h132, 16'h1101);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_model(12'h132, 16'h1101);
        run_frame(100, "after_rst");
        repeat (2) @(posedge clk);
        chk("after_rst_queue_empty", exp_q.size(), 0);

        // Back-to-back frames with start held high
        for (int k = 0; k < 3; k++) push_model(12'h132, 16'h1101);
        frames = 0;
        idle = 0;
        seen_busy = 1'b0;
        n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        while (frames < 3 && n < 400) begin
            @(posedge clk); #1;
            if (seen_busy && !busy) idle++;
            if (busy) seen_busy = 1'b1;
            if (done) begin
                frames++;
                if (frames == 3) start = 1'b0;
            end
            n++;
        end
        start = 1'b0;
        chk("b2b_frames", frames, 3);
        chk("b2b_gap_ok", (idle <= 3), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_queue_empty", exp_q.size(), 0);
        chk("b2b_idle_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
